arb_channel_requester: RTL and testbench



---
 rtl/arb_pkg.sv | 31 +++
 rtl/arb_chan_fifo.sv | 68 ++++++
 rtl/arb_channel_requester.sv | 149 ++++++++++++++
 tb/tb_arb_channel_requester.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and helpers for the 8-channel grant arbiter
//               requester endpoints. Holds the channel/grant sizing, the
//               requester state encoding and the grant-match function.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

  localparam int NUM_CHAN = 8;
  localparam int GRANT_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // A grant only matches when every bit is a known 0/1. The arbiter floats
  // the grant bus when nobody holds it, and that must never look like a hit.
  function automatic logic grant_is(input logic [GRANT_W-1:0] grant,
                                    input logic [GRANT_W-1:0] id);
    return ((^grant) !== 1'bx) && (grant == id);
  endfunction

endpackage

`default_nettype wire

// File: rtl/arb_chan_fifo.sv
// ============================================================================
// Module      : arb_chan_fifo
// Description : Synchronous first-word-fall-through FIFO for one requester
//               channel. A push into a full FIFO is accepted only when a pop
//               happens in the same cycle.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               push, din       - write request and data
//               pop             - read request (ignored while empty)
//               dout            - head word, valid whenever !empty
//               count           - number of stored words
//               full, empty     - combinational status from count
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_chan_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  // The slot freed by a same-cycle pop may be refilled immediately.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/arb_channel_requester.sv
// ============================================================================
// Module      : arb_channel_requester
// Description : Requester endpoint for one channel of the 8-channel grant
//               arbiter. Queues outbound words, raises req, and while the
//               shared grant equals CHAN_ID sends up to MAX_BURST words on
//               the shared data bus, then drops req for one RELEASE cycle so
//               the arbiter can rotate.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               wr_en, wr_data     - queue a word
//               full, empty        - FIFO status (combinational)
//               overflow           - 1-cycle pulse: write dropped while full
//               req                - registered request to arbiter ID<CHAN_ID>
//               grant              - arbiter grant bus (Z/X when idle)
//               bus_data/bus_valid - registered payload, data 0 when invalid
//               busy               - in REQ, XFER or RELEASE
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_channel_requester
  import arb_pkg::*;
#(
  parameter int CHAN_ID    = 0,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               full,
  output logic               empty,
  output logic               overflow,
  output logic               req,
  input  logic [GRANT_W-1:0] grant,
  output logic [DATA_W-1:0]  bus_data,
  output logic               bus_valid,
  output logic               busy
);

  localparam int                 CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [GRANT_W-1:0] CHAN_CODE = GRANT_W'(CHAN_ID);
  localparam logic [3:0]         LAST_BEAT = 4'(MAX_BURST);

  state_t            state;
  state_t            state_nx;
  logic [3:0]        beat_cnt;
  logic [3:0]        beat_cnt_nx;
  logic              req_nx;
  logic              bus_valid_nx;
  logic [DATA_W-1:0] bus_data_nx;

  logic              grant_hit;
  logic              pop;
  logic              push_ok;
  logic              last_beat;
  logic [DATA_W-1:0] head;
  logic [CNT_W-1:0]  count;

  arb_chan_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (pop),
    .din   (wr_data),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign grant_hit = grant_is(grant, CHAN_CODE);
  assign pop       = ((state == REQ) || (state == XFER)) && grant_hit && !empty;
  // Mirrors the FIFO's acceptance rule so the last-beat test sees the same
  // post-edge occupancy the FIFO will have.
  assign push_ok   = wr_en && (!full || pop);
  // Either the burst budget is used up or this pop drains the FIFO.
  assign last_beat = ((beat_cnt + 4'd1) == LAST_BEAT) ||
                     ((count == CNT_W'(1)) && !push_ok);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx     = state;
    beat_cnt_nx  = beat_cnt;
    req_nx       = req;
    bus_valid_nx = 1'b0;
    bus_data_nx  = '0;
    case (state)
      IDLE: begin
        req_nx = 1'b0;
        if (!empty) begin
          state_nx    = REQ;
          req_nx      = 1'b1;
          beat_cnt_nx = '0;
        end
      end
      REQ, XFER: begin
        // Without a hit (not yet granted, or preempted) req is held and the
        // beat count is kept so the tenure resumes where it stopped.
        req_nx = 1'b1;
        if (pop) begin
          bus_valid_nx = 1'b1;
          bus_data_nx  = head;
          beat_cnt_nx  = beat_cnt + 4'd1;
          if (last_beat) begin
            state_nx = RELEASE;
            req_nx   = 1'b0;
          end else begin
            state_nx = XFER;
          end
        end
      end
      RELEASE: begin
        // The grant seen here still reflects our old req; it is ignored.
        req_nx   = 1'b0;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        req_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      req       <= 1'b0;
      bus_valid <= 1'b0;
      bus_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nx;
      beat_cnt  <= beat_cnt_nx;
      req       <= req_nx;
      bus_valid <= bus_valid_nx;
      bus_data  <= bus_data_nx;
      overflow  <= wr_en && full && !pop;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arb_channel_requester.sv
// ============================================================================
// Module      : tb_arb_channel_requester
// Description : Self-checking bench for arb_channel_requester (CHAN_ID=2).
//               A registered arbiter model answers req; tasks can override
//               the grant bus. Sent words are scoreboarded in order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arb_channel_requester;

  localparam int CHAN_ID    = 2;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int MAX_BURST  = 4;

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              req;
  logic [3:0]        grant;
  logic [DATA_W-1:0] bus_data;
  logic              bus_valid;
  logic              busy;

  logic [3:0]        arb_grant;
  logic              ovr_en;
  logic [3:0]        ovr_val;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] send_q[$];
  int                tenure_q[$];
  bit                vhist[$];
  bit                rhist[$];
  int                tw;
  logic [DATA_W-1:0] exp_word;

  arb_channel_requester #(
    .CHAN_ID    (CHAN_ID),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .req       (req),
    .grant     (grant),
    .bus_data  (bus_data),
    .bus_valid (bus_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arbiter model: grant registered from req, floated when not requested.
  always @(posedge clk) arb_grant <= req ? 4'(CHAN_ID) : 4'bz;
  assign grant = ovr_en ? ovr_val : arb_grant;

  // Scoreboard: every valid bus word must be the oldest outstanding word.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got word %0h, required no word", bus_data);
        end else begin
          exp_word = exp_q.pop_front();
          if (bus_data !== exp_word) begin
            errors++;
            $display("FAIL sb_data: got %0h, required %0h", bus_data, exp_word);
          end
        end
      end else begin
        checks++;
        if (bus_data !== '0) begin
          errors++;
          $display("FAIL idle_data: got %0h, required 0", bus_data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hist();
    vhist.delete();
    rhist.delete();
    tenure_q.delete();
    tw = 0;
  endtask

  // Feed send_q into the FIFO whenever it has room and record per-cycle
  // bus_valid/req plus words per tenure (a tenure ends on a RELEASE sample).
  task automatic run(input int ncycles, input int stop_valid, output int nv);
    nv = 0;
    for (int c = 0; c < ncycles; c++) begin
      if (send_q.size() > 0 && !full) begin
        wr_en   = 1'b1;
        wr_data = send_q[0];
        exp_q.push_back(send_q.pop_front());
      end else begin
        wr_en = 1'b0;
      end
      tick();
      vhist.push_back(bus_valid);
      rhist.push_back(req);
      if (bus_valid) begin
        nv++;
        tw++;
      end
      if (busy && !req) begin
        tenure_q.push_back(tw);
        tw = 0;
      end
      if (stop_valid > 0 && nv == stop_valid) break;
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (req !== 1'b0)       begin errors++; $display("FAIL rst_req: got %b, required 0", req); end
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", bus_valid); end
    checks++; if (bus_data !== '0)    begin errors++; $display("FAIL rst_data: got %0h, required 0", bus_data); end
    checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL rst_ovf: got %b, required 0", overflow); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL rst_fifo: got empty=%b full=%b, required 1/0", empty, full); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int nv;
    int first;
    clear_hist();
    send_q = '{8'hA1, 8'hB2, 8'hC3};
    run(20, 0, nv);
    first = -1;
    for (int i = 0; i < vhist.size(); i++) if (vhist[i] && first < 0) first = i;
    checks++; if (first !== 3) begin errors++; $display("FAIL basic_latency: got first valid at %0d, required 3", first); end
    checks++;
    if (first < 0 || !(vhist[first] && vhist[first+1] && vhist[first+2] && !vhist[first+3])) begin
      errors++; $display("FAIL basic_run: valid run not 3 consecutive words");
    end
    checks++;
    if (first < 0 || !(rhist[first+1] && !rhist[first+2])) begin
      errors++; $display("FAIL basic_req: req did not fall with last word");
    end
    checks++; if (nv !== 3) begin errors++; $display("FAIL basic_count: got %0d words, required 3", nv); end
    checks++;
    if (tenure_q.size() != 1 || tenure_q[0] != 3) begin
      errors++; $display("FAIL basic_tenure: got %0d tenures, required one of 3 words", tenure_q.size());
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: busy got %b, required 0", busy); end
  endtask

  task automatic test_burst_limit();
    int nv;
    clear_hist();
    send_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    run(40, 0, nv);
    checks++; if (nv !== 6) begin errors++; $display("FAIL burst_count: got %0d words, required 6", nv); end
    checks++;
    if (tenure_q.size() != 2 || tenure_q[0] != 4 || tenure_q[1] != 2) begin
      errors++; $display("FAIL burst_split: got %0d tenures, required 4 then 2", tenure_q.size());
    end
  endtask

  task automatic test_preempt();
    int nv;
    int bad;
    clear_hist();
    send_q = '{8'h20, 8'h21, 8'h22, 8'h23};
    run(20, 1, nv);
    checks++; if (nv !== 1) begin errors++; $display("FAIL pre_start: got %0d words, required 1", nv); end
    ovr_en  = 1'b1;
    ovr_val = 4'd7;
    wr_en   = 1'b1;
    wr_data = 8'h24;
    exp_q.push_back(8'h24);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      wr_en = 1'b0;
      if (bus_valid !== 1'b0 || req !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL pre_hold: got %0d bad cycles, required 0 (valid=0 req=1)", bad); end
    ovr_en = 1'b0;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus_valid !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL pre_resume: got %0d missing words, required 0", bad); end
    checks++;
    if (req !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL pre_limit: got req=%b busy=%b, required release after 4 words", req, busy);
    end
    clear_hist();
    run(20, 0, nv);
    checks++; if (nv !== 1) begin errors++; $display("FAIL pre_rest: got %0d words, required 1", nv); end
  endtask

  task automatic test_stale_grant();
    int nv;
    clear_hist();
    send_q = '{8'h30};
    run(20, 1, nv);
    checks++;
    if (nv !== 1 || req !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL stale_setup: got words=%0d req=%b busy=%b, required 1/0/1", nv, req, busy);
    end
    ovr_en  = 1'b1;
    ovr_val = 4'(CHAN_ID);
    wr_en   = 1'b1;
    wr_data = 8'h31;
    exp_q.push_back(8'h31);
    tick();
    wr_en = 1'b0;
    checks++;
    if (bus_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL stale_release: got valid=%b busy=%b, required 0/0", bus_valid, busy);
    end
    tick();
    checks++;
    if (bus_valid !== 1'b0 || req !== 1'b1) begin
      errors++; $display("FAIL stale_rereq: got valid=%b req=%b, required 0/1", bus_valid, req);
    end
    ovr_en = 1'b0;
    clear_hist();
    run(20, 0, nv);
    checks++; if (nv !== 1) begin errors++; $display("FAIL stale_word: got %0d words, required 1", nv); end
  endtask

  task automatic test_fifo_bounds();
    int nv;
    int bad;
    clear_hist();
    ovr_en  = 1'b1;
    ovr_val = 4'bz;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'h40 + 8'(i);
      if (i < 4) exp_q.push_back(8'h40 + 8'(i));
      tick();
      if (bus_valid !== 1'b0) bad++;
      if (i == 3) begin
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fifo_full: got %b, required 1", full); end
      end
    end
    wr_en = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fifo_ovf: got %b, required 1", overflow); end
    tick();
    if (bus_valid !== 1'b0) bad++;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fifo_ovf_pulse: got %b, required 0", overflow); end
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL fifo_req: got %b, required 1", req); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL fifo_nogrant: got %0d valid cycles, required 0", bad); end
    ovr_val = 4'(CHAN_ID);
    wr_en   = 1'b1;
    wr_data = 8'h4F;
    exp_q.push_back(8'h4F);
    tick();
    wr_en  = 1'b0;
    ovr_en = 1'b0;
    checks++;
    if (bus_valid !== 1'b1 || overflow !== 1'b0 || full !== 1'b1) begin
      errors++; $display("FAIL fifo_pushpop: got valid=%b ovf=%b full=%b, required 1/0/1", bus_valid, overflow, full);
    end
    run(40, 0, nv);
    checks++; if (nv !== 4) begin errors++; $display("FAIL fifo_drain: got %0d words, required 4", nv); end
  endtask

  task automatic test_reset_mid_burst();
    int nv;
    int bad;
    clear_hist();
    send_q = '{8'h50, 8'h51, 8'h52, 8'h53};
    run(30, 2, nv);
    checks++; if (nv !== 2) begin errors++; $display("FAIL mid_setup: got %0d words, required 2", nv); end
    rst = 1'b1;
    tick();
    checks++;
    if (req !== 1'b0 || bus_valid !== 1'b0 || empty !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_rst: got req=%b valid=%b empty=%b busy=%b, required 0/0/1/0", req, bus_valid, empty, busy);
    end
    exp_q.delete();
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus_valid !== 1'b0 || req !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mid_quiet: got %0d active cycles, required 0", bad); end
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    ovr_en  = 1'b0;
    ovr_val = 4'd0;
    tw      = 0;
    test_reset();
    test_basic();
    test_burst_limit();
    test_preempt();
    test_stale_grant();
    test_fifo_bounds();
    test_reset_mid_burst();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_drained: got %0d words outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
